// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer
// Packs a 32-bit valid/ack user stream into BFT packets addressed to a configured
// (leaf, port). Traffic is paced by credits returned by the destination leaf.
//
// Ports
//   clk            : single clock
//   reset          : asynchronous, active-high
//   cfg_en         : enable; destination fields are latched on the IDLE->RUN transition
//   cfg_dst_leaf   : destination leaf
//   cfg_dst_port   : destination port (1..15, 0 is the credit/control port)
//   din_user       : user data word
//   vld_user       : user word valid
//   ack_user       : word accepted this cycle (combinational)
//   din_bft        : packets from the BFT (credit returns)
//   dout_bft       : packets to the BFT, all-zero when nothing is launched
//   resend         : BFT back-pressure, blocks new launches
//   credit_cnt     : current credit
//   err_credit_ovf : sticky, a credit return would have exceeded buffer depth
module leaf_stream_packetizer #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_en,
  input  logic [NUM_LEAF_BITS-1:0]      cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]      cfg_dst_port,
  input  logic [PAYLOAD_BITS-1:0]       din_user,
  input  logic                          vld_user,
  output logic                          ack_user,
  input  logic [PACKET_BITS-1:0]        din_bft,
  output logic [PACKET_BITS-1:0]        dout_bft,
  input  logic                          resend,
  output logic [NUM_BRAM_ADDR_BITS:0]   credit_cnt,
  output logic                          err_credit_ovf
);

  localparam int unsigned CreditW = NUM_BRAM_ADDR_BITS + 1;
  localparam int unsigned SumW    = CreditW + 1;
  localparam logic [CreditW-1:0] CreditMax = CreditW'(1) << NUM_BRAM_ADDR_BITS;
  localparam logic [SumW-1:0]    UpdateAmt = SumW'(FREESPACE_UPDATE_SIZE);

  // Field offsets inside a packet
  localparam int unsigned PortLsb = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int unsigned LeafLsb = PortLsb + NUM_PORT_BITS;

  typedef enum logic [1:0] {StIdle, StRun, StBlocked} state_e;

  state_e                     state_q, state_d;
  logic [NUM_LEAF_BITS-1:0]   leaf_q, leaf_d;
  logic [NUM_PORT_BITS-1:0]   port_q, port_d;
  logic [NUM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [CreditW-1:0]         credit_q, credit_d;
  logic                       err_q, err_d;
  logic [PACKET_BITS-1:0]     dout_q, dout_d;

  logic                       ack;
  logic                       credit_ret;
  logic [SumW-1:0]            credit_sum;

  // Credit packets arrive on port 0; the destination port that issued them is carried in
  // the low bits of the address field.
  assign credit_ret = din_bft[PACKET_BITS-1]
                    && (din_bft[PortLsb +: NUM_PORT_BITS] == '0)
                    && (din_bft[PAYLOAD_BITS +: NUM_PORT_BITS] == port_q);

  assign ack = vld_user && (state_q == StRun) && (credit_q != '0) && !resend;

  logic unused_din;
  assign unused_din = ^{din_bft[LeafLsb +: NUM_LEAF_BITS],
                        din_bft[PAYLOAD_BITS + NUM_PORT_BITS +: NUM_ADDR_BITS - NUM_PORT_BITS],
                        din_bft[PAYLOAD_BITS-1:0]};

  // Credit update: one extra bit so an over-return can be detected before clamping.
  always_comb begin
    credit_sum = {1'b0, credit_q};
    if (credit_ret) credit_sum = credit_sum + UpdateAmt;
    if (ack)        credit_sum = credit_sum - SumW'(1);
    credit_d = credit_sum[CreditW-1:0];
    err_d    = err_q;
    if (credit_sum > {1'b0, CreditMax}) begin
      credit_d = CreditMax;
      err_d    = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    leaf_d  = leaf_q;
    port_d  = port_q;
    addr_d  = addr_q;
    dout_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (cfg_en) begin
          leaf_d  = cfg_dst_leaf;
          port_d  = cfg_dst_port;
          addr_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!cfg_en)                state_d = StIdle;
        else if (credit_q == '0)    state_d = StBlocked;
      end
      StBlocked: begin
        if (!cfg_en)                state_d = StIdle;
        else if (credit_q != '0)    state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    // Accepts only happen in RUN, so this never collides with the IDLE address clear.
    if (ack) begin
      addr_d = addr_q + NUM_ADDR_BITS'(1);
      dout_d = {1'b1, leaf_q, port_q, addr_q, din_user};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      leaf_q   <= '0;
      port_q   <= '0;
      addr_q   <= '0;
      credit_q <= CreditMax;
      err_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      leaf_q   <= leaf_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
    end
  end

  assign ack_user       = ack;
  assign dout_bft       = dout_q;
  assign credit_cnt     = credit_q;
  assign err_credit_ovf = err_q;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
module tb_leaf_stream_packetizer;

  logic        clk;
  logic        reset;
  logic        cfg_en;
  logic [4:0]  cfg_dst_leaf;
  logic [3:0]  cfg_dst_port;
  logic [31:0] din_user;
  logic        vld_user;
  logic        ack_user;
  logic [48:0] din_bft;
  logic [48:0] dout_bft;
  logic        resend;
  logic [7:0]  credit_cnt;
  logic        err_credit_ovf;

  leaf_stream_packetizer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_en         (cfg_en),
    .cfg_dst_leaf   (cfg_dst_leaf),
    .cfg_dst_port   (cfg_dst_port),
    .din_user       (din_user),
    .vld_user       (vld_user),
    .ack_user       (ack_user),
    .din_bft        (din_bft),
    .dout_bft       (dout_bft),
    .resend         (resend),
    .credit_cnt     (credit_cnt),
    .err_credit_ovf (err_credit_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = idle, 1 = sending, 2 = stalled for credit
  int          m_mode;
  int          m_credit;
  int          m_addr;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  logic        m_err;
  logic [48:0] m_dout;

  // Values sampled in the most recent step
  logic        s_ack;
  logic [48:0] s_dout;
  logic [7:0]  s_credit;
  logic        s_err;

  typedef struct {
    logic        en;
    logic [4:0]  leaf;
    logic [3:0]  port;
    logic        vld;
    logic [31:0] din;
    logic        exp_ack;
    logic [48:0] exp_dout;
    logic [7:0]  exp_credit;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [48:0] pkt(logic [4:0] l, logic [3:0] p, int a, logic [31:0] w);
    logic [6:0] a7;
    a7 = 7'(a);
    return {1'b1, l, p, a7, w};
  endfunction

  function automatic logic [48:0] cr_pkt(logic [3:0] p);
    return {1'b1, 5'd0, 4'd0, 3'd0, p, 32'd0};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_credit = 128; m_addr = 0;
    m_leaf = '0; m_port = '0; m_err = 1'b0; m_dout = '0;
  endtask

  // Inputs are set just after a rising edge; sample, compare against the model, advance it.
  task automatic step();
    logic e_ack;
    logic ret;
    int   nc;
    #1;
    s_ack = ack_user; s_dout = dout_bft; s_credit = credit_cnt; s_err = err_credit_ovf;
    e_ack = vld_user && (m_mode == 1) && (m_credit != 0) && !resend;
    check("ack", 64'(s_ack), 64'(e_ack));
    check("dout", 64'(s_dout), 64'(m_dout));
    check("credit", 64'(s_credit), 64'(m_credit));
    check("err", 64'(s_err), 64'(m_err));

    ret = din_bft[48] && (din_bft[42:39] == 4'd0) && (din_bft[35:32] == m_port);
    nc = m_credit + (ret ? 64 : 0) - (e_ack ? 1 : 0);
    if (nc > 128) begin
      nc = 128;
      m_err = 1'b1;
    end
    m_dout = e_ack ? pkt(m_leaf, m_port, m_addr, din_user) : '0;
    if (e_ack) m_addr = (m_addr + 1) % 128;
    case (m_mode)
      0: if (cfg_en) begin
        m_leaf = cfg_dst_leaf; m_port = cfg_dst_port; m_addr = 0; m_mode = 1;
      end
      1: if (!cfg_en) m_mode = 0; else if (m_credit == 0) m_mode = 2;
      default: if (!cfg_en) m_mode = 0; else if (m_credit > 0) m_mode = 1;
    endcase
    m_credit = nc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_en = 1'b0; cfg_dst_leaf = '0; cfg_dst_port = '0; din_user = '0;
    vld_user = 1'b0; din_bft = '0; resend = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start(logic [4:0] l, logic [3:0] p);
    cfg_en = 1'b1; cfg_dst_leaf = l; cfg_dst_port = p;
    vld_user = 1'b0; resend = 1'b0; din_bft = '0;
    step();
  endtask

  task automatic stream_n(int n);
    int got = 0;
    vld_user = 1'b1;
    for (int c = 0; c < 4 * n + 20 && got < n; c++) begin
      din_user = $urandom;
      step();
      if (s_ack) got++;
    end
    check("stream_count", 64'(got), 64'(n));
    vld_user = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests so far", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    int thr;
    int r;

    tbl[0] = '{1'b1, 5'd3, 4'd2, 1'b0, 32'h0,  1'b0, 49'h0,                     8'd128};
    tbl[1] = '{1'b1, 5'd3, 4'd2, 1'b1, 32'hA0, 1'b1, 49'h0,                     8'd128};
    tbl[2] = '{1'b1, 5'd3, 4'd2, 1'b1, 32'hA1, 1'b1, pkt(5'd3, 4'd2, 0, 32'hA0), 8'd127};
    tbl[3] = '{1'b1, 5'd3, 4'd2, 1'b1, 32'hA2, 1'b1, pkt(5'd3, 4'd2, 1, 32'hA1), 8'd126};
    tbl[4] = '{1'b1, 5'd3, 4'd2, 1'b1, 32'hA3, 1'b1, pkt(5'd3, 4'd2, 2, 32'hA2), 8'd125};
    tbl[5] = '{1'b1, 5'd3, 4'd2, 1'b1, 32'hA4, 1'b1, pkt(5'd3, 4'd2, 3, 32'hA3), 8'd124};
    tbl[6] = '{1'b1, 5'd3, 4'd2, 1'b0, 32'h0,  1'b0, pkt(5'd3, 4'd2, 4, 32'hA4), 8'd123};
    tbl[7] = '{1'b1, 5'd3, 4'd2, 1'b0, 32'h0,  1'b0, 49'h0,                     8'd123};

    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check("reset_dout", 64'(dout_bft), 64'd0);
    check("reset_credit", 64'(credit_cnt), 64'd128);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic five-word burst
    for (int i = 0; i < 8; i++) begin
      cfg_en = tbl[i].en; cfg_dst_leaf = tbl[i].leaf; cfg_dst_port = tbl[i].port;
      vld_user = tbl[i].vld; din_user = tbl[i].din;
      step();
      check("t1_ack", 64'(s_ack), 64'(tbl[i].exp_ack));
      check("t1_dout", 64'(s_dout), 64'(tbl[i].exp_dout));
      check("t1_credit", 64'(s_credit), 64'(tbl[i].exp_credit));
    end

    // Exhaust credit, block, recover, address wraps
    do_reset();
    start(5'd3, 4'd2);
    vld_user = 1'b1;
    acks = 0;
    for (int i = 0; i < 130; i++) begin
      din_user = $urandom;
      step();
      if (s_ack) acks++;
    end
    check("t2_acks", 64'(acks), 64'd128);
    check("t2_credit0", 64'(s_credit), 64'd0);
    din_bft = {1'b1, 5'd0, 4'd0, 7'd2, 32'd0};
    step();
    check("t2_blocked_ack", 64'(s_ack), 64'd0);
    din_bft = '0;
    step();
    check("t2_credit64", 64'(s_credit), 64'd64);
    check("t2_still_blocked", 64'(s_ack), 64'd0);
    din_user = 32'h1234_5678;
    step();
    check("t2_resume", 64'(s_ack), 64'd1);
    din_user = $urandom;
    step();
    check("t2_wrap_pkt", 64'(s_dout), 64'(pkt(5'd3, 4'd2, 0, 32'h1234_5678)));

    // Credit return coincident with an accept
    do_reset();
    start(5'd1, 4'd4);
    stream_n(118);
    vld_user = 1'b1; din_user = 32'hCAFE; din_bft = cr_pkt(4'd4);
    step();
    check("t3_ack", 64'(s_ack), 64'd1);
    check("t3_credit10", 64'(s_credit), 64'd10);
    vld_user = 1'b0; din_bft = '0;
    step();
    check("t3_credit73", 64'(s_credit), 64'd73);

    // Over-return clamps and sets the sticky flag
    do_reset();
    start(5'd2, 4'd9);
    stream_n(28);
    din_bft = cr_pkt(4'd9);
    step();
    din_bft = '0;
    step();
    check("t4_clamp", 64'(s_credit), 64'd128);
    check("t4_err", 64'(s_err), 64'd1);
    stream_n(5);
    step();
    check("t4_err_sticky", 64'(s_err), 64'd1);
    do_reset();
    step();
    check("t4_err_cleared", 64'(s_err), 64'd0);

    // Back-pressure mid-stream
    start(5'd6, 4'd3);
    stream_n(4);
    vld_user = 1'b1;
    resend = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_user = $urandom;
      step();
      check("t5_ack_hold", 64'(s_ack), 64'd0);
      if (i > 0) check("t5_dout_hold", 64'(s_dout), 64'd0);
    end
    resend = 1'b0;
    step();
    check("t5_dout_gap", 64'(s_dout), 64'd0);
    check("t5_ack_resume", 64'(s_ack), 64'd1);
    stream_n(4);
    step();

    // Asynchronous reset mid-burst
    stream_n(3);
    check("t6_pre", 64'(dout_bft != '0), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_dout0", 64'(dout_bft), 64'd0);
    check("t6_credit", 64'(credit_cnt), 64'd128);
    check("t6_ack0", 64'(ack_user), 64'd0);
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    start(5'd9, 4'd7);
    vld_user = 1'b1; din_user = 32'hDEAD_BEEF;
    step();
    check("t6_ack", 64'(s_ack), 64'd1);
    vld_user = 1'b0;
    step();
    check("t6_pkt", 64'(s_dout), 64'(pkt(5'd9, 4'd7, 0, 32'hDEAD_BEEF)));
    check("t6_credit127", 64'(s_credit), 64'd127);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      thr = (i < 1500) ? 5 : 30;
      cfg_en       = ($urandom_range(0, 99) != 0);
      cfg_dst_leaf = 5'($urandom);
      cfg_dst_port = 4'($urandom_range(1, 15));
      vld_user     = ($urandom_range(0, 99) < 70);
      resend       = ($urandom_range(0, 99) < 15);
      din_user     = $urandom;
      r = $urandom_range(0, 999);
      if (r < thr)            din_bft = cr_pkt(m_port);
      else if (r < thr + 40)  din_bft = {1'b1, 16'($urandom), 32'($urandom)};
      else                    din_bft = '0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
